bitwise_logic_acc: RTL and testbench
====================================

Name: bitwise_logic_acc

Overview:
Parametrised, registered successor to the 16-bit combinational bitwise gates. It applies one of eight bitwise operations to two WIDTH-bit operands and returns the result through a one-entry output register with a valid/ready handshake. An optional accumulate mode replaces operand A with an internal accumulator, so OR/AND/XOR-reduction runs over a stream of words. It sits between the gate library and the ALU/datapath as a reusable logic stage.

Parameters:
WIDTH, 16, operand/result width in bits (>=1)
CNT_W, 8, width of the accepted-transaction counter (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
inValid  input  1  request carries valid operands
inReady  output  1  block can accept a request this cycle
op  input  3  operation select (see Behaviour)
inA  input  WIDTH  operand A (ignored when accEn=1)
inB  input  WIDTH  operand B
accEn  input  1  use accumulator as operand A; write result back to accumulator
accClear  input  1  clear accumulator
out  output  WIDTH  registered result
outValid  output  1  out holds an unconsumed result
outReady  input  1  downstream consumes out this cycle
zero  output  1  registered: out == 0
allOnes  output  1  registered: out == all ones
count  output  CNT_W  number of accepted requests, modulo 2^CNT_W

Behaviour:
- Reset (synchronous, active-high, at clk edge): out=0, outValid=0, zero=1, allOnes=0, acc=0, count=0. Reset mid-operation discards any pending result and accumulator contents; no transaction is accepted in the reset cycle.
- op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 pass A. All ops are purely bitwise; no carries. The result is exactly WIDTH bits.
- Operand A source:
  - accEn=0: A=inA.
  - accEn=1 and accClear=0: A=acc.
  - accEn=1 and accClear=1: A=0.
- inReady = !outValid || outReady, combinational. There is no dependency of inReady on inValid.
- Accept = inValid && inReady. On accept:
  - out <= result; zero/allOnes are updated from result.
  - outValid <= 1.
  - count <= count+1, wrapping at 2^CNT_W to 0.
  - If accEn=1, acc <= result.
- Latency: a result appears on out with outValid=1 the cycle after accept. Full throughput of one per cycle when outReady is held at 1.
- Consume without accept (outValid && outReady && !Accept): outValid <= 0. out, zero and allOnes hold their last values.
- Backpressure (outValid=1, outReady=0): inReady=0, and out/outValid/zero/allOnes/acc/count all hold. Upstream must hold its request.
- accClear:
  - Without accept: acc <= 0 at the edge.
  - With an accepted accEn=1 request: A=0 for that request and acc <= result, so the result has priority over the clear.
  - With an accepted accEn=0 request: acc <= 0.
- op values, operands and accEn are sampled only on accept. Changes while not accepted have no effect.
- acc is not visible on a port. It is observed by issuing op=7 (pass A) with accEn=1.

Test Plan:
- After reset, with inValid=0: out=0x0000, outValid=0, zero=1, allOnes=0, count=0, inReady=1.
- op=1, inA=0x1234, inB=0x9876, single beat with outReady=1 -> next cycle out=0x9A76, outValid=1, zero=0, count=1. Repeat for op=0 -> 0x1034, op=2 -> 0x8A42, op=3 -> 0xEFCB.
- op=2, inA=0xAAAA, inB=0x5555 -> out=0xFFFF, allOnes=1. op=4 with the same operands -> out=0x0000, zero=1. op=6, inA=0x00FF -> out=0xFF00.
- Accumulate OR: beat 1 with accEn=1, accClear=1, inB=0x000F; then accEn=1 with inB=0x00F0, then inB=0x0F00 -> outs 0x000F, 0x00FF, 0x0FFF. A following op=7 with accEn=1 returns 0x0FFF. accClear alone, then op=7 with accEn=1 -> 0x0000.
- Backpressure: outReady=0 with two back-to-back requests (0x0001 OR 0x0002, then 0x0004 OR 0x0008) -> first out=0x0003 and held, inReady=0, count=1. Raise outReady -> second out=0x000C, count=2, with no loss or duplication.
- Build with CNT_W=4 and issue 17 accepted requests -> count=1. Assert reset while outValid=1 -> next cycle outValid=0, out=0x0000, count=0, and acc reads back 0x0000.

Source files
------------

// File: rtl/bitwise_logic_acc.sv
// Registered bitwise logic stage: eight bitwise ops on two operands, a one-entry
// output register with valid/ready handshake, and an optional accumulator for operand A.
module bitwise_logic_acc #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             accEn,
  input  logic             accClear,
  output logic [WIDTH-1:0] out,
  output logic             outValid,
  input  logic             outReady,
  output logic             zero,
  output logic             allOnes,
  output logic [CNT_W-1:0] count
);

  // Handshake: a beat transfers on any edge where valid and ready are both high.
  // Input side: inReady depends only on the output register (never on inValid).
  // Output side: outValid stays high with out stable until outReady is seen.

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_acc;
  logic             r_out_valid;
  logic             r_zero;
  logic             r_all_ones;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_result;

  assign inReady  = !r_out_valid || outReady;
  assign w_accept = inValid && inReady;

  // A clear alongside an accumulate beat zeroes operand A rather than the result.
  assign w_op_a = accEn ? (accClear ? '0 : r_acc) : inA;

  always_comb begin
    w_result = '0;
    case (op)
      3'd0: w_result = w_op_a & inB;
      3'd1: w_result = w_op_a | inB;
      3'd2: w_result = w_op_a ^ inB;
      3'd3: w_result = ~(w_op_a & inB);
      3'd4: w_result = ~(w_op_a | inB);
      3'd5: w_result = ~(w_op_a ^ inB);
      3'd6: w_result = ~w_op_a;
      3'd7: w_result = w_op_a;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b1;
      r_all_ones  <= 1'b0;
      r_acc       <= '0;
      r_count     <= '0;
    end else if (w_accept) begin
      r_out       <= w_result;
      r_out_valid <= 1'b1;
      r_zero      <= (w_result == '0);
      r_all_ones  <= (w_result == '1);
      r_count     <= r_count + 1'b1;
      if (accEn) begin
        r_acc <= w_result;
      end else if (accClear) begin
        r_acc <= '0;
      end
    end else begin
      if (r_out_valid && outReady) begin
        r_out_valid <= 1'b0;
      end
      if (accClear) begin
        r_acc <= '0;
      end
    end
  end

  assign out      = r_out;
  assign outValid = r_out_valid;
  assign zero     = r_zero;
  assign allOnes  = r_all_ones;
  assign count    = r_count;

endmodule

// File: tb/tb_bitwise_logic_acc.sv
// Self-checking bench for bitwise_logic_acc: directed vector table, hand-written
// accumulate/backpressure/wrap/reset sequences, and randomized traffic against a truth-table model.
module tb_bitwise_logic_acc;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          inValid;
  logic          inReady;
  logic [2:0]    op;
  logic [W-1:0]  inA;
  logic [W-1:0]  inB;
  logic          accEn;
  logic          accClear;
  logic [W-1:0]  out;
  logic          outValid;
  logic          outReady;
  logic          zero;
  logic          allOnes;
  logic [CW-1:0] count;

  bitwise_logic_acc #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .op(op), .inA(inA), .inB(inB), .accEn(accEn), .accClear(accClear),
    .out(out), .outValid(outValid), .outReady(outReady),
    .zero(zero), .allOnes(allOnes), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: per-op truth table indexed by {a_bit, b_bit}.
  logic [3:0]   tt [8];
  logic [W-1:0] m_out;
  logic         m_valid;
  logic [W-1:0] m_acc;
  int           m_count;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_out;
    logic         exp_zero;
    logic         exp_all;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [W-1:0] ref_fn(input logic [2:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [3:0]   t;
    t = tt[f];
    for (int i = 0; i < W; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check pre-edge handshake, advance model and DUT, check registered outputs.
  task automatic tick();
    logic         ready;
    logic         acc_now;
    logic [W-1:0] a;
    logic [W-1:0] res;
    logic [W-1:0] popped;
    #1;
    ready = !m_valid || outReady;
    check("inReady", {31'd0, inReady}, {31'd0, ready});
    if (m_valid && outReady && !reset) begin
      if (exp_q.size() == 0) begin
        check("consume_empty_queue", 32'd1, 32'd0);
      end else begin
        popped = exp_q.pop_front();
        check("consumed_out", {16'd0, out}, {16'd0, popped});
      end
    end
    acc_now = inValid && ready && !reset;
    a   = accEn ? (accClear ? '0 : m_acc) : inA;
    res = ref_fn(op, a, inB);
    @(posedge clk);
    if (reset) begin
      m_out = '0; m_valid = 1'b0; m_acc = '0; m_count = 0;
      exp_q.delete();
    end else if (acc_now) begin
      m_out   = res;
      m_valid = 1'b1;
      m_count = (m_count + 1) % (1 << CW);
      if (accEn) m_acc = res;
      else if (accClear) m_acc = '0;
      exp_q.push_back(res);
    end else begin
      if (m_valid && outReady) m_valid = 1'b0;
      if (accClear) m_acc = '0;
    end
    #1;
    check("out", {16'd0, out}, {16'd0, m_out});
    check("outValid", {31'd0, outValid}, {31'd0, m_valid});
    check("zero", {31'd0, zero}, {31'd0, (m_out == '0)});
    check("allOnes", {31'd0, allOnes}, {31'd0, (m_out == '1)});
    check("count", {28'd0, count}, m_count);
  endtask

  task automatic beat(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic en, input logic clr, input logic v, input logic rdy);
    reset = 1'b0; op = f; inA = a; inB = b; accEn = en; accClear = clr;
    inValid = v; outReady = rdy;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; inValid = 1'b0; accEn = 1'b0; accClear = 1'b0; outReady = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
    m_out = '0; m_valid = 1'b0; m_acc = '0; m_count = 0;
    reset = 1'b1; inValid = 1'b0; op = '0; inA = '0; inB = '0;
    accEn = 1'b0; accClear = 1'b0; outReady = 1'b1;

    vecs[0] = '{3'd1, 16'h1234, 16'h9876, 16'h9A76, 1'b0, 1'b0};
    vecs[1] = '{3'd0, 16'h1234, 16'h9876, 16'h1034, 1'b0, 1'b0};
    vecs[2] = '{3'd2, 16'h1234, 16'h9876, 16'h8A42, 1'b0, 1'b0};
    vecs[3] = '{3'd3, 16'h1234, 16'h9876, 16'hEFCB, 1'b0, 1'b0};
    vecs[4] = '{3'd2, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b1};
    vecs[5] = '{3'd4, 16'hAAAA, 16'h5555, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{3'd6, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0};
    vecs[7] = '{3'd5, 16'h1234, 16'h9876, 16'h75BD, 1'b0, 1'b0};
    vecs[8] = '{3'd7, 16'hC3A5, 16'h0000, 16'hC3A5, 1'b0, 1'b0};
    vecs[9] = '{3'd1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};

    // Reset state.
    do_reset();
    beat(3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_out", {16'd0, out}, 32'h0);
    check("rst_outValid", {31'd0, outValid}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_allOnes", {31'd0, allOnes}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_inReady", {31'd0, inReady}, 32'd1);

    // Directed vector table, single beats with outReady held high.
    for (int i = 0; i < 10; i++) begin
      beat(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, 1'b1, 1'b1);
      check($sformatf("vec%0d_out", i), {16'd0, out}, {16'd0, vecs[i].exp_out});
      check($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].exp_zero});
      check($sformatf("vec%0d_allOnes", i), {31'd0, allOnes}, {31'd0, vecs[i].exp_all});
      check($sformatf("vec%0d_valid", i), {31'd0, outValid}, 32'd1);
    end
    beat(3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Accumulate OR chain, readback, clear.
    beat(3'd1, 16'hDEAD, 16'h000F, 1'b1, 1'b1, 1'b1, 1'b1);
    check("acc1", {16'd0, out}, 32'h000F);
    beat(3'd1, 16'hDEAD, 16'h00F0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("acc2", {16'd0, out}, 32'h00FF);
    beat(3'd1, 16'hDEAD, 16'h0F00, 1'b1, 1'b0, 1'b1, 1'b1);
    check("acc3", {16'd0, out}, 32'h0FFF);
    beat(3'd7, 16'hBEEF, 16'h1111, 1'b1, 1'b0, 1'b1, 1'b1);
    check("acc_readback", {16'd0, out}, 32'h0FFF);
    beat(3'd0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(3'd7, 16'hBEEF, 16'h1111, 1'b1, 1'b0, 1'b1, 1'b1);
    check("acc_cleared", {16'd0, out}, 32'h0000);
    beat(3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure with two back-to-back requests.
    do_reset();
    beat(3'd1, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_first", {16'd0, out}, 32'h0003);
    for (int i = 0; i < 3; i++) begin
      beat(3'd1, 16'h0004, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0);
      check("bp_hold_out", {16'd0, out}, 32'h0003);
      check("bp_hold_count", {28'd0, count}, 32'd1);
      check("bp_inReady", {31'd0, inReady}, 32'd0);
    end
    beat(3'd1, 16'h0004, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b1);
    check("bp_second", {16'd0, out}, 32'h000C);
    check("bp_count2", {28'd0, count}, 32'd2);
    beat(3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_drained", {31'd0, outValid}, 32'd0);
    check("bp_out_hold", {16'd0, out}, 32'h000C);

    // Counter wrap with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      beat(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
    end
    check("wrap_count", {28'd0, count}, 32'd1);

    // Reset while a result is pending and the accumulator holds data.
    beat(3'd1, '0, 16'h5A5A, 1'b1, 1'b1, 1'b1, 1'b0);
    check("pre_rst_valid", {31'd0, outValid}, 32'd1);
    do_reset();
    check("mid_rst_valid", {31'd0, outValid}, 32'd0);
    check("mid_rst_out", {16'd0, out}, 32'h0);
    check("mid_rst_count", {28'd0, count}, 32'd0);
    beat(3'd7, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1);
    check("mid_rst_acc", {16'd0, out}, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      inValid  = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 2) != 0);
      op       = 3'($urandom_range(0, 7));
      inA      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      inB      = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      accEn    = ($urandom_range(0, 1) == 1);
      accClear = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
